// File: rtl/adder_sweep_checker_pkg.sv
// Shared definitions for the adder sweep checker: FSM state encoding and
// width helpers derived from the operand width.
package adder_sweep_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Width of the DUT sum: one carry bit above the operands.
   function automatic int sum_w(input int n);
      return n + 1;
   endfunction

   // Width of the error counter: must hold 2^(2n) mismatches.
   function automatic int cnt_w(input int n);
      return 2 * n + 1;
   endfunction

   // Width of the settle counter; at least one bit even when SETTLE is 1.
   function automatic int settle_w(input int settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/sweep_vector_counter.sv
// 2n-bit operand-pair counter. The high half is operand A, the low half is
// operand B, so B increments fastest and carries into A.
module sweep_vector_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] value,
   output logic         wrap
);

   // Counter register: clear has priority over increment.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (en) begin
         value <= value + W'(1);
      end
   end

   // The next increment rolls over to zero: this is the last vector.
   assign wrap = &value;

endmodule

// File: rtl/adder_sweep_checker.sv
// Exhaustive stimulus/compare engine for an n-bit adder. Walks every (a, b)
// pair, holds each for SETTLE cycles, then compares dut_sum against the
// full-width golden sum and records error count and first failure.
module adder_sweep_checker
   import adder_sweep_checker_pkg::*;
#(
   parameter int n      = 4,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic [n-1:0] a_out,
   output logic [n-1:0] b_out,
   input  logic [n:0]   dut_sum,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [2*n:0] err_count,
   output logic [n-1:0] fail_a,
   output logic [n-1:0] fail_b,
   output logic [n:0]   fail_sum
);

   localparam int SUM_W = sum_w(n);
   localparam int CNT_W = cnt_w(n);
   localparam int SET_W = settle_w(SETTLE);
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

   state_t           state;
   logic [SET_W-1:0] settle_cnt;
   logic [2*n-1:0]   vec;
   logic             vec_wrap;
   logic             sweep_go;
   logic [SUM_W-1:0] expected;
   logic             mismatch;
   logic [CNT_W-1:0] err_next;

   // A new sweep may only be launched from IDLE or DONE.
   assign sweep_go = ((state == ST_IDLE) || (state == ST_DONE)) && start;

   sweep_vector_counter #(
      .W (2 * n)
   ) u_vec (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sweep_go),
      .en    (state == ST_CHECK),
      .value (vec),
      .wrap  (vec_wrap)
   );

   assign a_out = vec[2*n-1:n];
   assign b_out = vec[n-1:0];

   // Golden sum and mismatch detection for the vector currently applied.
   always_comb begin
      // NOTE: every signal is assigned on every pass, so no latch is inferred.
      expected = {1'b0, a_out} + {1'b0, b_out};
      mismatch = (dut_sum != expected);
      err_next = err_count + CNT_W'(mismatch);
   end

   // Sweep sequencer with registered status, error count and first-fail capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_sum   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_APPLY;
                  settle_cnt <= SETTLE_LOAD;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_a     <= '0;
                  fail_b     <= '0;
                  fail_sum   <= '0;
               end
            end
            ST_APPLY: begin
               if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - SET_W'(1);
               end else begin
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               err_count <= err_next;
               if (mismatch && (err_count == '0)) begin
                  fail_a   <= a_out;
                  fail_b   <= b_out;
                  fail_sum <= dut_sum;
               end
               if (vec_wrap) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  state      <= ST_APPLY;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/adder_sweep_checker.md
Name: adder_sweep_checker

Overview:
Self-checking stimulus/compare engine for the n-bit adder labs. It drives every operand pair (a, b) into an adder under test and samples the returned sum. It compares that sum against an internally computed golden result and reports pass/fail plus error count and first failure. It is the initiator/consumer on the adder interface, while the adder (RCA or golden model) is the responder. It sits between board controls (start button, LEDs/7-seg) and the DUT.

Parameters:
n, 4, operand width; DUT sum is n+1 bits
SETTLE, 1, cycles operands are held before sampling dut_sum (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  level; sampled only in IDLE or DONE
a_out  output  n  operand A to DUT
b_out  output  n  operand B to DUT
dut_sum  input  n+1  sum returned by DUT (combinational w.r.t. a_out/b_out)
busy  output  1  high while sweep in progress
done  output  1  high in DONE state
pass  output  1  high in DONE when err_count==0
err_count  output  2n+1  number of mismatching vectors this sweep
fail_a  output  n  A of first mismatch
fail_b  output  n  B of first mismatch
fail_sum  output  n+1  dut_sum captured at first mismatch

Behaviour:
- Reset (rst_n low at clk edge) forces state IDLE and clears every output and internal register: a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_a/fail_b/fail_sum=0, settle counter=0. Reset mid-sweep aborts immediately; no partial result is retained.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE: start=1 -> APPLY. In the same edge: a_out=0, b_out=0, err_count and fail_* cleared, settle counter=SETTLE-1, busy=1.
- APPLY: operands held stable. Counter>0 -> decrement. Counter==0 -> CHECK. Occupancy is exactly SETTLE cycles per vector.
- CHECK (1 cycle): expected = {1'b0,a_out}+{1'b0,b_out}, full n+1 bits, no truncation.
  - On mismatch with dut_sum: err_count+1. If err_count was 0, capture fail_a=a_out, fail_b=b_out, fail_sum=dut_sum.
  - Advance {a_out,b_out} as one 2n-bit counter; b_out is the low half, so b increments fastest and carries into a.
  - If {a_out,b_out} was all ones: wrap to 0 and go to DONE. Otherwise reload the settle counter and go to APPLY.
- err_count max is 2^(2n), which fits in 2n+1 bits; no saturation logic is needed.
- DONE: busy=0, done=1, pass=(err_count==0). Results hold indefinitely. start=1 starts a new sweep exactly as from IDLE, clearing the results.
- start is ignored in APPLY/CHECK. A held start re-triggers every time DONE is reached.
- Sweep length: 2^(2n)*(SETTLE+1) cycles from the start edge to the edge entering DONE.
- All outputs are registered; none depends combinationally on dut_sum.
- busy and done are never both 1.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_APPLY, ST_CHECK, ST_DONE, 2 bits) and width helpers (SUM_W=n+1, CNT_W=2n+1).
- One sub-module: sweep_vector_counter. It is a 2n-bit counter with load-zero, enable, and wrap flag, and it feeds a_out/b_out.
- Compare and first-fail capture stay in the top level.

Test Plan:
- n=2, SETTLE=1, correct DUT (RCA_verification instance), pulse start -> DONE entered 32 cycles after start edge; err_count=0, pass=1, fail_*=0.
- n=2, SETTLE=1, DUT with sum[0] stuck at 0 -> err_count=8 (odd a+b pairs); fail_a=0, fail_b=1, fail_sum=0; pass=0.
- n=2, SETTLE=3, correct DUT -> a_out/b_out change only every 4 cycles; DONE after 64 cycles; vector order (0,0),(0,1),(0,2),(0,3),(1,0)...
- Pulse start again during busy at vector (1,2) -> ignored; sweep completes at the same cycle as without the pulse.
- Reset low for one cycle mid-sweep at vector (2,1) -> next cycle IDLE, all outputs 0; a new start gives a full sweep from (0,0).
- From DONE with err_count=8, assert start with a correct DUT -> err_count and fail_* clear on the start edge; final pass=1.
